matrix_scan_driver: RTL
=======================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter ROWS, default 8: number of matrix rows and columns; fixed at 8 for this revision.
REQ-002 Parameter DWELL_CYCLES, default 1024: clk cycles each row is lit; legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port row_data  input  16: pixel row from the game renderer; bit i lights column i; bits [15:8] are ignored.
REQ-006 Port count  output  3: row index requested from the renderer; the renderer registers row_data one clk after sampling count.
REQ-007 Port row_sel  output  8: one-hot, active-high row enable; bit r drives row r.
REQ-008 Port col_out  output  8: active-high column drive for the currently enabled row.
REQ-009 Port frame_start  output  1: one-cycle pulse marking the start of each frame.

Function
REQ-010 The block SHALL implement three states: BLANK, FETCH and SHOW.
REQ-011 BLANK SHALL last 1 cycle, with row_sel=0 and col_out=0; count SHALL already hold the new row index r on entry.
REQ-012 FETCH SHALL last 1 cycle with row_sel=0 and col_out=0; on its closing edge the block SHALL latch row_data[7:0] into the column register.
REQ-013 SHOW SHALL last exactly DWELL_CYCLES cycles, with row_sel=(1<<r) and col_out=the latched column register.
REQ-014 On leaving SHOW, the block SHALL enter BLANK with count=r+1, wrapping from 7 to 0 (3-bit modulo).
REQ-015 Row period SHALL be DWELL_CYCLES+2 cycles; frame period SHALL be 8*(DWELL_CYCLES+2) cycles.
REQ-016 row_sel and col_out SHALL never be nonzero in BLANK or FETCH; no two row_sel bits SHALL ever be high together.
REQ-017 frame_start SHALL be 1 only during the FETCH cycle where count==0.
REQ-018 Changes on row_data outside the FETCH closing edge SHALL NOT affect col_out.
REQ-019 The dwell counter SHALL be ceil(log2(DWELL_CYCLES+1)) bits, reset to 0 on SHOW entry, with terminal count DWELL_CYCLES-1.
REQ-020 With DWELL_CYCLES=1, SHOW SHALL last exactly 1 cycle.

Reset
REQ-021 While rst=1, asynchronously: state=BLANK, count=0, row_sel=0, col_out=0, frame_start=0, dwell counter=0, column register=0.
REQ-022 Reset asserted mid-SHOW SHALL blank row_sel and col_out without waiting for a clk edge.
REQ-023 The first cycle after rst deasserts SHALL be BLANK for row 0, followed by FETCH with frame_start=1.

Configuration
REQ-024 With macro MATRIX_SCAN_BRIGHTNESS_EN defined, the block SHALL add input brightness[2:0] and sample it in BLANK.
REQ-025 With MATRIX_SCAN_BRIGHTNESS_EN defined, col_out SHALL be forced to 0 during SHOW once the dwell counter is >= ((brightness+1)*DWELL_CYCLES)/8 (integer division); row_sel timing SHALL be unchanged.
REQ-026 With MATRIX_SCAN_BRIGHTNESS_EN defined, brightness=7 SHALL give full duty, identical to the macro-undefined build.
REQ-027 Without MATRIX_SCAN_BRIGHTNESS_EN, the brightness port and its logic SHALL be absent and col_out SHALL show full duty.

Structure
REQ-028 Package matrix_pkg SHALL hold ROWS, the scan state enum (BLANK/FETCH/SHOW) and the BRIGHT_STEPS=8 constant.
REQ-029 Sub-module scan_dwell_timer SHALL hold the dwell counter, with inputs start/clk/rst and outputs done/count_value; the FSM, row counter and output registers SHALL stay in matrix_scan_driver.

Verification (DWELL_CYCLES=4 unless stated)
REQ-030 Release reset and hold row_data=16'h00A5 -> FETCH with frame_start=1 on cycle 2, then row_sel=8'h01 and col_out=8'hA5 for cycles 3..6, then count=1 on cycle 7.
REQ-031 Run 48 cycles with a renderer model -> exactly 8 SHOW windows, row_sel 01,02,..,80, frame_start pulses 48 cycles apart, and count wraps 7->0.
REQ-032 Toggle row_data every cycle during SHOW -> col_out stays at the value latched at FETCH end.
REQ-033 Assert rst asynchronously mid-SHOW of row 5 -> row_sel=0 and col_out=0 before the next clk edge; after release, the scan restarts at row 0.
REQ-034 With MATRIX_SCAN_BRIGHTNESS_EN defined, DWELL_CYCLES=8 and brightness=1 -> col_out is live for 2 SHOW cycles, then 0 for 6.
REQ-035 Checker over the whole run: row_sel one-hot or zero every cycle, and zero in all BLANK/FETCH cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and scan-state encoding for the LED matrix scan driver.
package matrix_pkg;

    localparam int ROWS         = 8;
    localparam int BRIGHT_STEPS = 8;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter for one lit row: cleared by start, counts up and parks at DWELL_CYCLES-1.
module scan_dwell_timer #(
    parameter int DWELL_CYCLES = 1024,
    localparam int CW = $clog2(DWELL_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic [CW-1:0] count_value
);

    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_value <= '0;
        end else if (start) begin
            count_value <= '0;
        end else if (count_value != LAST) begin
            count_value <= count_value + 1'b1;
        end
    end

    assign done = (count_value == LAST);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scanning driver for an 8x8 LED matrix: BLANK -> FETCH -> SHOW per row.
// Optional duty-cycle dimming is enabled with `define MATRIX_SCAN_BRIGHTNESS_EN.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS         = matrix_pkg::ROWS,
    parameter int DWELL_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    input  logic [2:0]      brightness,
`endif
    input  logic [15:0]     row_data,
    output logic [2:0]      count,
    output logic [ROWS-1:0] row_sel,
    output logic [7:0]      col_out,
    output logic            frame_start
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);

    scan_state_t   state;
    logic [7:0]    col_reg;
    logic          dwell_done;
    logic [CW-1:0] dwell_count;
    logic          fetch_live;
    logic          show_live;
    logic          unused_row_hi;

    assign unused_row_hi = ^row_data[15:8];

    scan_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk         (clk),
        .rst         (rst),
        .start       (state == FETCH),
        .done        (dwell_done),
        .count_value (dwell_count)
    );

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [2:0]  bright_reg;
    logic [19:0] bright_thr;
    logic [CW:0] next_dwell;

    // col_out is registered, so gating looks at the dwell value of the upcoming cycle
    always_comb begin
        bright_thr = ((20'(bright_reg) + 20'd1) * 20'(DWELL_CYCLES)) / 20'(BRIGHT_STEPS);
        next_dwell = {1'b0, dwell_count} + 1'b1;
        fetch_live = (bright_thr != 20'd0);
        show_live  = (20'(next_dwell) < bright_thr);
    end
`else
    always_comb begin
        fetch_live = 1'b1;
        show_live  = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            count       <= '0;
            row_sel     <= '0;
            col_out     <= '0;
            frame_start <= 1'b0;
            col_reg     <= '0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
            bright_reg  <= '0;
`endif
        end else begin
            case (state)
                BLANK: begin
                    state       <= FETCH;
                    frame_start <= (count == 3'd0);
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
                    bright_reg  <= brightness;
`endif
                end
                FETCH: begin
                    state       <= SHOW;
                    frame_start <= 1'b0;
                    col_reg     <= row_data[7:0];
                    row_sel     <= {{(ROWS-1){1'b0}}, 1'b1} << count;
                    col_out     <= fetch_live ? row_data[7:0] : '0;
                end
                SHOW: begin
                    if (dwell_done) begin
                        state   <= BLANK;
                        count   <= count + 3'd1;
                        row_sel <= '0;
                        col_out <= '0;
                    end else begin
                        col_out <= show_live ? col_reg : '0;
                    end
                end
                default: begin
                    state       <= BLANK;
                    row_sel     <= '0;
                    col_out     <= '0;
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
